// File: rtl/sw_array_ctrl_pkg.sv
// Shared types for the Smith-Waterman array sequencer: FSM encoding, base code
// and the length clamp applied when a pass is started.
package sw_array_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } sw_state_e;

    // 2-bit nucleotide code carried on the s/t paths
    typedef logic [1:0] base_t;

    localparam int VEF_W_DEFAULT = 16;

    // Zero becomes 1; a non-zero max_len caps the result (max_len==0 means unbounded).
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        if (len == 0) return 1;
        if ((max_len != 0) && (len > max_len)) return max_len;
        return len;
    endfunction

endpackage

// File: rtl/sw_array_ctrl_len_counter.sv
// Clear/increment counter with a terminal-count compare; one instance is reused
// by the LOAD, STREAM and DRAIN phases of the sequencer.
module sw_len_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] last,
    output logic [W-1:0] cnt,
    output logic         at_last
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)      cnt_d = '0;
        else if (inc) cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign cnt     = cnt_q;
    assign at_last = (cnt_q == last);

endmodule

// File: rtl/sw_array_ctrl.sv
// Sequencer for the linear Smith-Waterman PE array: loads a query segment, streams
// one target into PE0, drains the pipeline and pulses done.
module sw_array_ctrl
    import sw_array_ctrl_pkg::*;
#(
    parameter int NUM_PE = 16,
    parameter int LEN_W  = 16,
    parameter int QLEN_W = 5,
    parameter int VEF_W  = VEF_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [QLEN_W-1:0] query_len,
    input  logic [LEN_W-1:0]  target_len,
    input  logic              s_valid,
    input  base_t             s_data,
    output logic              s_ready,
    input  logic              t_valid,
    input  base_t             t_data,
    output logic              t_ready,
    output logic              arr_s_shift,
    output base_t             arr_s,
    output base_t             arr_t,
    output logic              arr_newline,
    output logic [VEF_W-1:0]  arr_vin,
    output logic [VEF_W-1:0]  arr_vin_a,
    output logic [VEF_W-1:0]  arr_fin,
    output logic              busy,
    output logic              done,
    output logic              err_underflow
);

    sw_state_e        state_q, state_d;
    logic [LEN_W-1:0] qlen_q, qlen_d;
    logic [LEN_W-1:0] tlen_q, tlen_d;
    logic             err_q, err_d;

    logic             arr_s_shift_q, arr_s_shift_d;
    base_t            arr_s_q, arr_s_d;
    base_t            arr_t_q, arr_t_d;
    logic             arr_newline_q, arr_newline_d;

    logic             cnt_clr, cnt_inc, cnt_at_last;
    logic [LEN_W-1:0] cnt_last, cnt;
    logic             s_xfer, t_xfer;

    assign s_ready = (state_q == ST_LOAD);
    assign t_ready = (state_q == ST_STREAM);
    assign s_xfer  = s_valid && s_ready;
    assign t_xfer  = t_valid && t_ready;

    sw_len_counter #(.W(LEN_W)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .last    (cnt_last),
        .cnt     (cnt),
        .at_last (cnt_at_last)
    );

    always_comb begin
        state_d  = state_q;
        qlen_d   = qlen_q;
        tlen_d   = tlen_q;
        err_d    = err_q;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        cnt_last = qlen_q - LEN_W'(1);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    qlen_d  = LEN_W'(clamp_len(32'(query_len), NUM_PE));
                    tlen_d  = LEN_W'(clamp_len(32'(target_len), 0));
                    err_d   = 1'b0;
                    cnt_clr = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (s_xfer) begin
                    if (cnt_at_last) begin
                        cnt_clr = 1'b1;
                        state_d = ST_STREAM;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                cnt_last = tlen_q - LEN_W'(1);
                if (t_valid) begin
                    if (cnt_at_last) begin
                        cnt_clr = 1'b1;
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end else if (cnt != '0) begin
                    // PEs cannot stall once a row is in flight: abandon the pass
                    err_d   = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cnt_at_last) begin
                    cnt_clr = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        arr_s_shift_d = s_xfer;
        arr_s_d       = s_xfer ? s_data : arr_s_q;
        arr_t_d       = t_xfer ? t_data : 2'd0;
        arr_newline_d = t_xfer && (cnt == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            qlen_q        <= '0;
            tlen_q        <= '0;
            err_q         <= 1'b0;
            arr_s_shift_q <= 1'b0;
            arr_s_q       <= 2'd0;
            arr_t_q       <= 2'd0;
            arr_newline_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            qlen_q        <= qlen_d;
            tlen_q        <= tlen_d;
            err_q         <= err_d;
            arr_s_shift_q <= arr_s_shift_d;
            arr_s_q       <= arr_s_d;
            arr_t_q       <= arr_t_d;
            arr_newline_q <= arr_newline_d;
        end
    end

    assign arr_s_shift   = arr_s_shift_q;
    assign arr_s         = arr_s_q;
    assign arr_t         = arr_t_q;
    assign arr_newline   = arr_newline_q;
    assign arr_vin       = '0;
    assign arr_vin_a     = '0;
    assign arr_fin       = '0;
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign err_underflow = err_q;

endmodule
